// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit.
//   OP_*        3-bit function select encodings
//   LU_MAX_W    widest operand logic_eval supports
//   logic_eval  combinational gate function, bitwise or reduction over a
package logic_unit_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_BUF  = 3'd7;

   localparam int LU_MAX_W = 64;

   // Operands arrive zero-extended to LU_MAX_W. The mask limits reductions to the
   // real operand width; for AND-type reductions the unused upper bits are forced
   // to 1 so they do not pull the result low.
   function automatic logic [LU_MAX_W-1:0] logic_eval(
      input logic [2:0]          op,
      input logic                red,
      input int unsigned         width,
      input logic [LU_MAX_W-1:0] a,
      input logic [LU_MAX_W-1:0] b
   );
      logic [LU_MAX_W-1:0] mask;
      logic [LU_MAX_W-1:0] am;
      logic [LU_MAX_W-1:0] y;
      logic                r;
      mask = (width >= LU_MAX_W) ? '1 : ((LU_MAX_W'(1) << width) - LU_MAX_W'(1));
      am   = a & mask;
      y    = '0;
      r    = 1'b0;
      if (red) begin
         case (op)
            OP_AND:  r = &(a | ~mask);
            OP_OR:   r = |am;
            OP_NAND: r = ~&(a | ~mask);
            OP_NOR:  r = ~|am;
            OP_XOR:  r = ^am;
            OP_XNOR: r = ~^am;
            OP_NOT:  r = ~a[0];
            default: r = a[0];
         endcase
         y[0] = r;
      end else begin
         case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            default: y = a;
         endcase
      end
      return y & mask;
   endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One pipeline slot: a valid bit plus payload register.
//   clk, rst   clock, synchronous active-high reset (clears valid only)
//   i_load     slot takes the upstream entry (slot empty or draining this cycle)
//   i_valid    upstream entry present
//   i_data     upstream payload
//   o_valid    slot occupied
//   o_data     slot payload
module logic_pipe_stage #(
   parameter int PW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic          i_valid,
   input  logic [PW-1:0] i_data,
   output logic          o_valid,
   output logic [PW-1:0] o_data
);

   logic          r_valid;
   logic [PW-1:0] r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= i_valid;
      end
   end

   // Payload is meaningless while the slot is empty, so it is not reset.
   always_ff @(posedge clk) begin
      if (i_load && i_valid) begin
         r_data <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise/reduction logic unit with valid/ready on both sides.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_op, in_red       function select, reduction-mode select
//   in_a, in_b          operands
//   out_valid/out_ready output handshake
//   out_y               result (0 while out_valid=0)
//   out_zero, out_ones  result all-zero / all-one flags (0 while out_valid=0)
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_red,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_ones
);

   // Payload layout: {y, zero, ones}
   localparam int PW = WIDTH + 2;

   logic [WIDTH-1:0]  w_y;
   logic              w_zero;
   logic              w_ones;
   logic [PW-1:0]     w_eval;
   logic [STAGES-1:0] w_v;
   logic [STAGES-1:0] w_load;
   logic [PW-1:0]     w_data [STAGES];
   logic              w_take;

   assign w_y    = WIDTH'(logic_eval(in_op, in_red, WIDTH, LU_MAX_W'(in_a), LU_MAX_W'(in_b)));
   assign w_zero = (w_y == '0);
   assign w_ones = &w_y;
   assign w_eval = {w_y, w_zero, w_ones};

   // Ready chain from the output back to the input: a slot may load when it is
   // empty or when whatever it holds is taken downstream this cycle.
   always_comb begin
      w_load = '0;
      w_take = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_load[k] = ~w_v[k] | w_take;
         w_take    = w_load[k];
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_head
         logic_pipe_stage #(.PW(PW)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[g]),
            .i_valid (in_valid),
            .i_data  (w_eval),
            .o_valid (w_v[g]),
            .o_data  (w_data[g])
         );
      end else begin : g_body
         logic_pipe_stage #(.PW(PW)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[g]),
            .i_valid (w_v[g-1]),
            .i_data  (w_data[g-1]),
            .o_valid (w_v[g]),
            .o_data  (w_data[g])
         );
      end
   end

   assign in_ready  = ~rst & w_load[0];
   assign out_valid = w_v[STAGES-1];
   assign {out_y, out_zero, out_ones} = out_valid ? w_data[STAGES-1] : '0;

endmodule
